alu_cmd_sequencer: RTL and testbench

//  Upstream front-end for the 8-bit ALU (ADD/SUB/TWO/XOR, 2-bit op_code).
//  - Accepts commands over a valid/ready handshake and drives the ALU's op_a, op_b and op_code from registers.
//  - Waits a fixed settle time, then captures the ALU's out and carry_out.
//  - Presents the captured result downstream over a valid/ready handshake.
//  - Keeps an accumulator so that command chains can reuse the previous result as op_a.

---
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer - command front-end for an 8-bit ALU with settle timer,
// result capture, accumulator chaining and valid/ready on both sides.
module alu_cmd_sequencer #(
  parameter int         WIDTH         = 8,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [1:0] OP_ADD        = 2'b00,
  parameter logic [1:0] OP_SUB        = 2'b01,
  parameter logic [1:0] OP_TWO        = 2'b10,
  parameter logic [1:0] OP_XOR        = 2'b11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op_a,
  input  logic [WIDTH-1:0] in_op_b,
  input  logic [1:0]       in_op_code,
  input  logic             in_use_acc,
  output logic [WIDTH-1:0] alu_op_a,
  output logic [WIDTH-1:0] alu_op_b,
  output logic [1:0]       alu_op_code,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  // Op codes pass straight through, but they must still be four distinct encodings.
  if (SETTLE_CYCLES < 1 || OP_ADD == OP_SUB || OP_ADD == OP_TWO || OP_ADD == OP_XOR ||
      OP_SUB == OP_TWO || OP_SUB == OP_XOR || OP_TWO == OP_XOR) begin : g_bad_params
    $error("alu_cmd_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESULT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]       op_code_q, op_code_d;
  logic [WIDTH-1:0] res_data_q, res_data_d, acc_q, acc_d;
  logic             res_carry_q, res_carry_d;
  logic             accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_code_d   = op_code_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    acc_d       = acc_q;
    in_ready    = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_data_d  = alu_out;
          res_carry_d = alu_carry;
          acc_d       = alu_out;
          state_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        in_ready = res_ready;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rst_n) in_ready = 1'b0;
    accept = in_valid && in_ready;

    // In RESULT the consume and the new accept share one edge; acc_q already holds the capture.
    if (accept) begin
      op_a_d    = in_use_acc ? acc_q : in_op_a;
      op_b_d    = in_op_b;
      op_code_d = in_op_code;
      cnt_d     = CNT_LOAD;
      state_d   = ST_SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_code_q   <= op_code_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      acc_q       <= acc_d;
    end
  end

  assign alu_op_a    = op_a_q;
  assign alu_op_b    = op_b_q;
  assign alu_op_code = op_code_q;
  assign res_valid   = (state_q == ST_RESULT);
  assign res_data    = res_data_q;
  assign res_carry   = res_carry_q;
  assign res_zero    = (res_data_q == '0);
  assign acc         = acc_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer - randomized and directed bench with a transaction-level
// reference model and a behavioural ALU attached to the sequencer.
module tb_alu_cmd_sequencer;

  localparam int S = 3;

  logic       clk, rst_n;
  logic       in_valid, in_ready, in_use_acc;
  logic [7:0] in_op_a, in_op_b;
  logic [1:0] in_op_code;
  logic [7:0] alu_op_a, alu_op_b, alu_out;
  logic [1:0] alu_op_code;
  logic       alu_carry;
  logic       res_valid, res_ready, res_carry, res_zero, busy;
  logic [7:0] res_data, acc;

  alu_cmd_sequencer #(.WIDTH(8), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .in_op_code(in_op_code), .in_use_acc(in_use_acc),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .acc(acc), .busy(busy)
  );

  // Behavioural ALU: SUB carry is the borrow, TWO is the two's complement of op_a.
  function automatic logic [8:0] alu_golden(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
    int ia = int'(a);
    int ib = int'(b);
    int r;
    logic c;
    case (op)
      2'b00:   begin r = ia + ib;          c = (r > 255); end
      2'b01:   begin r = ia - ib;          c = (ia < ib); end
      2'b10:   begin r = 256 - ia;         c = (ia == 0); end
      default: begin r = int'(a ^ b);      c = 1'b0;      end
    endcase
    return {c, 8'(r & 255)};
  endfunction

  always_comb {alu_carry, alu_out} = alu_golden(alu_op_a, alu_op_b, alu_op_code);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] r;
    logic       c;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_acc;
  int         checks, failures;
  int         since, cyc, n_acc, n_res, n_abort;
  bit         after_rst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, want, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level monitor; samples on the falling edge, updates the model for the next rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("in_ready_in_reset", in_ready, 0);
      n_abort   += exp_q.size();
      exp_q.delete();
      m_acc     = 8'h00;
      since     = -1;
      after_rst = 1'b1;
    end else begin
      if (since >= 0) since++;
      if (after_rst) begin
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_res_zero", res_zero, 1);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_carry", res_carry, 0);
        check_eq("rst_acc", acc, 0);
        check_eq("rst_alu_ops", {alu_op_a, alu_op_b, alu_op_code}, 0);
        after_rst = 1'b0;
      end
      check_eq("busy", busy, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check_eq("alu_op_a", alu_op_a, exp_q[0].a);
        check_eq("alu_op_b", alu_op_b, exp_q[0].b);
        check_eq("alu_op_code", alu_op_code, exp_q[0].op);
      end
      if (since >= 1 && since <= S) begin
        check_eq("settle_res_valid", res_valid, 0);
        check_eq("settle_in_ready", in_ready, 0);
      end
      if (since == S + 1) check_eq("latency_res_valid", res_valid, 1);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("res_unexpected", res_valid, 0);
        end else begin
          check_eq("res_data", res_data, exp_q[0].r);
          check_eq("res_carry", res_carry, exp_q[0].c);
          check_eq("res_zero", res_zero, exp_q[0].r == 8'h00);
          check_eq("acc", acc, exp_q[0].r);
        end
        check_eq("in_ready_result", in_ready, res_ready);
      end else if (exp_q.size() == 0) begin
        check_eq("in_ready_idle", in_ready, 1);
      end
      if (res_valid && res_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_res++;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.a  = in_use_acc ? m_acc : in_op_a;
        e.b  = in_op_b;
        e.op = in_op_code;
        {e.c, e.r} = alu_golden(e.a, e.b, e.op);
        m_acc = e.r;
        exp_q.push_back(e);
        since = 0;
        n_acc++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ua, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input bit rnd);
    bit done;
    done       = 1'b0;
    in_valid   = 1'b1;
    in_use_acc = ua;
    in_op_a    = a;
    in_op_b    = b;
    in_op_code = op;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rnd) res_ready = ($urandom % 3) != 0;
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check_eq("accept_timeout", done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    checks = 0; failures = 0; since = -1; cyc = 0;
    n_acc = 0; n_res = 0; n_abort = 0; after_rst = 1'b0; m_acc = 8'h00;
    rst_n = 1'b0; in_valid = 1'b0; in_use_acc = 1'b0;
    in_op_a = 8'h00; in_op_b = 8'h00; in_op_code = 2'b00; res_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    send(1'b0, 8'h7F, 8'h01, 2'b00, 1'b0);
    check_eq("t1_alu_op_a_registered", alu_op_a, 8'h7F);
    tick(S + 2);
    check_eq("t1_acc", acc, 8'h80);
    send(1'b0, 8'hFF, 8'h01, 2'b00, 1'b0);
    tick(S + 2);
    check_eq("t2_acc", acc, 8'h00);

    send(1'b0, 8'h10, 8'h05, 2'b00, 1'b0);
    send(1'b1, 8'hAA, 8'h03, 2'b00, 1'b0);
    check_eq("t3_chain_op_a", alu_op_a, 8'h15);
    send(1'b1, 8'h00, 8'hFF, 2'b11, 1'b0);
    tick(S + 2);
    check_eq("t3_chain_xor", acc, 8'hE7);

    res_ready = 1'b0;
    send(1'b0, 8'h21, 8'h12, 2'b01, 1'b0);
    in_valid = 1'b1; in_use_acc = 1'b1; in_op_b = 8'h0F; in_op_code = 2'b11;
    tick(S + 1 + 5);
    res_ready = 1'b1;
    c0 = cyc;
    send(1'b1, 8'h00, 8'h0F, 2'b11, 1'b0);
    check_eq("t4_release_same_edge", cyc - c0, 1);
    tick(S + 2);

    send(1'b0, 8'h33, 8'h44, 2'b00, 1'b0);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(S + 3);
    check_eq("t5_no_result_after_abort", res_valid, 0);

    c0 = cyc;
    for (int k = 0; k < 4; k++)
      send(k[0], 8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
    check_eq("t6_b2b_interval", cyc - c0, 1 + 3 * (S + 1));
    tick(S + 2);

    for (int k = 0; k < 40; k++) begin
      send(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1);
      if ($urandom % 4 == 0) tick($urandom_range(1, 3));
    end
    res_ready = 1'b1;
    tick(S + 4);
    check_eq("drain_empty", exp_q.size(), 0);
    check_eq("result_count", n_res, n_acc - n_abort);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
